// File: rtl/bin_mult_ctrl.sv
// Wishbone-mapped controller for an iterative shift-add unsigned multiplier.
// Owns the operand/result registers, the multiply sequencer and the done/irq flags.
module bin_mult_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffOpa    = 3'd1;
  localparam logic [2:0] OffOpb    = 3'd2;
  localparam logic [2:0] OffResult = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;

  logic [1:0]       state_q, state_d;
  logic             ack_q;
  logic             req_we_q;
  logic [2:0]       req_off_q;
  logic [31:0]      req_dat_q;
  logic [3:0]       req_sel_q;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, mplier_q, mplier_d;
  logic [PW-1:0]    mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             irq_en_q, irq_en_d, done_q, done_d;

  logic             hit, req, busy, wr, start_go;
  logic [WIDTH-1:0] lane_mask;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Never accept in the ack cycle, so ack cannot stay high two cycles running.
  assign req  = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
  assign busy = (state_q != StIdle);
  assign wr   = ack_q & req_we_q;
  assign start_go = wr & (req_off_q == OffCtrl) & req_sel_q[0] & req_dat_q[0] & ~busy;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      lane_mask[i] = req_sel_q[i / 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;

    case (state_q)
      StIdle: begin
        if (start_go) state_d = StLoad;
      end
      StLoad: begin
        mcand_d  = PW'(opa_q);
        mplier_d = opb_q;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = StRun;
      end
      StRun: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        result_d = acc_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (wr && (req_off_q == OffCtrl) && req_sel_q[0]) irq_en_d = req_dat_q[1];

    // Operands are frozen while a multiply is in flight.
    if (wr && !busy) begin
      if (req_off_q == OffOpa) opa_d = (opa_q & ~lane_mask) | (req_dat_q[WIDTH-1:0] & lane_mask);
      if (req_off_q == OffOpb) opb_d = (opb_q & ~lane_mask) | (req_dat_q[WIDTH-1:0] & lane_mask);
    end

    if (start_go || (wr && !busy && (req_off_q == OffStatus) && req_dat_q[1])) done_d = 1'b0;
    if (state_q == StDone) done_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (ack_q && !req_we_q) begin
      case (req_off_q)
        OffCtrl:   rdata[1]          = irq_en_q;
        OffOpa:    rdata[WIDTH-1:0]  = opa_q;
        OffOpb:    rdata[WIDTH-1:0]  = opb_q;
        OffResult: rdata[PW-1:0]     = result_q;
        OffStatus: rdata[1:0]        = {done_q, busy};
        default:   rdata             = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      req_we_q  <= 1'b0;
      req_off_q <= '0;
      req_dat_q <= '0;
      req_sel_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= req;
      if (req) begin
        req_we_q  <= wbs_we_i;
        req_off_q <= wbs_adr_i[4:2];
        req_dat_q <= wbs_dat_i;
        req_sel_q <= wbs_sel_i;
      end
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata;
  assign irq_o     = done_q & irq_en_q;
  assign busy_o    = busy;
  assign done_o    = done_q;

  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], req_dat_q, req_sel_q};

endmodule
